// File: rtl/phaethon_mem_arbiter_if.sv
// phaethon_mem_arbiter_if
//   Bundle of the requester-side and RAM-side signals of phaethon_mem_arbiter.
//   Modports are named from the arbiter's point of view:
//     master : the arbiter (drives RAM address/data/strobes and channel completions)
//     slave  : the surroundings (requesters plus the physical RAM)
//   Signals:
//     chReadReq/chWriteReq [NUM_CH]        level requests, held until chRamReady
//     chAddress  [NUM_CH*ADDR_W]           packed per-channel address
//     chWrite    [NUM_CH*DATA_W]           packed per-channel write data
//     chRamRead  [DATA_W]                  read data broadcast to all channels
//     chRamReady [NUM_CH]                  one-hot one-cycle completion pulse
//     phRamRead  [DATA_W]                  physical RAM read data
//     phRamAddress/phRamWrite              physical RAM address / write data
//     phReadReq/phWriteReq                 physical RAM strobes
interface phaethon_mem_arbiter_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [NUM_CH-1:0]        chReadReq;
  logic [NUM_CH-1:0]        chWriteReq;
  logic [NUM_CH*ADDR_W-1:0] chAddress;
  logic [NUM_CH*DATA_W-1:0] chWrite;
  logic [DATA_W-1:0]        chRamRead;
  logic [NUM_CH-1:0]        chRamReady;
  logic [DATA_W-1:0]        phRamRead;
  logic [ADDR_W-1:0]        phRamAddress;
  logic [DATA_W-1:0]        phRamWrite;
  logic                     phReadReq;
  logic                     phWriteReq;

  modport master (
    input  chReadReq, chWriteReq, chAddress, chWrite, phRamRead,
    output chRamRead, chRamReady, phRamAddress, phRamWrite, phReadReq, phWriteReq
  );

  modport slave (
    output chReadReq, chWriteReq, chAddress, chWrite, phRamRead,
    input  chRamRead, chRamReady, phRamAddress, phRamWrite, phReadReq, phWriteReq
  );
endinterface

// File: rtl/phaethon_mem_arbiter.sv
// phaethon_mem_arbiter
//   Shares one fixed-latency physical RAM port between NUM_CH requesters.
//   Round-robin arbitration by default; define MEMARB_FIXED_PRIO_EN for fixed
//   priority (lowest pending channel wins, no round-robin pointer).
//   One access at a time: IDLE -> READ (RD_LATENCY cycles) or WRITE (1 cycle)
//   -> DONE (chRamReady pulse) -> IDLE. All bus outputs come straight from flops.
//   Ports:
//     clk      : system clock, rising edge
//     reset    : asynchronous active-high reset
//     bus      : phaethon_mem_arbiter_if.master (requester and RAM signals)
//     arbDebug : {24'b0, state[1:0], errSticky, grant[3:0], busy}
module phaethon_mem_arbiter #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  phaethon_mem_arbiter_if.master bus,
  output logic [31:0]           arbDebug
);

  localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PadN = 1 << IdxW;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   grant_q, grant_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_CH-1:0] ready_q, ready_d;
  logic              rd_req_q, rd_req_d;
  logic              wr_req_q, wr_req_d;

  logic [IdxW-1:0]   rr_ptr;
  logic [PadN-1:0]   rd_pad, wr_pad, pend_pad;
  logic              win_vld;
  logic [IdxW-1:0]   win_idx;
  logic [IdxW-1:0]   cand;
  int unsigned       idx;

  // Padding to a power of two lets any IdxW-wide index select safely.
  assign rd_pad   = PadN'(bus.chReadReq);
  assign wr_pad   = PadN'(bus.chWriteReq);
  assign pend_pad = rd_pad | wr_pad;

`ifdef MEMARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [IdxW-1:0] rr_ptr_q;

  // Next search starts just past the channel that was last served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else if (state_q == StDone) begin
      rr_ptr_q <= IdxW'((32'(grant_q) + 32'd1) % NUM_CH);
    end
  end

  assign rr_ptr = rr_ptr_q;
`endif

  // First pending channel searching upward from rr_ptr, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx  = (32'(rr_ptr) + k) % NUM_CH;
      cand = IdxW'(idx);
      if (!win_vld && pend_pad[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rd_req_d = rd_req_q;
    wr_req_d = 1'b0;
    ready_d  = '0;
    unique case (state_q)
      StIdle: begin
        rd_req_d = 1'b0;
        if (win_vld) begin
          grant_d = win_idx;
          addr_d  = bus.chAddress[32'(win_idx) * ADDR_W +: ADDR_W];
          if (wr_pad[win_idx]) begin
            // A write wins over a simultaneous read; the conflict is latched.
            wdata_d  = bus.chWrite[32'(win_idx) * DATA_W +: DATA_W];
            wr_req_d = 1'b1;
            state_d  = StWrite;
            if (rd_pad[win_idx]) begin
              err_d = 1'b1;
            end
          end else begin
            rd_req_d = 1'b1;
            cnt_d    = 4'(RD_LATENCY - 1);
            state_d  = StRead;
          end
        end
      end
      StRead: begin
        if (cnt_q == 4'd0) begin
          rdata_d  = bus.phRamRead;
          ready_d  = NUM_CH'(1) << grant_q;
          rd_req_d = 1'b0;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWrite: begin
        ready_d = NUM_CH'(1) << grant_q;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= '0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
    end
  end

  assign bus.chRamRead    = rdata_q;
  assign bus.chRamReady   = ready_q;
  assign bus.phRamAddress = addr_q;
  assign bus.phRamWrite   = wdata_q;
  assign bus.phReadReq    = rd_req_q;
  assign bus.phWriteReq   = wr_req_q;

  assign arbDebug = {24'b0, state_q, err_q, 4'(grant_q), state_q != StIdle};

endmodule

// File: tb/tb_phaethon_mem_arbiter.sv
// tb_phaethon_mem_arbiter
//   Scoreboard bench for phaethon_mem_arbiter with NUM_CH=4, RD_LATENCY=3.
//   Expected completions are queued in predicted grant order when requests are
//   driven and checked as chRamReady pulses appear. A small RAM model returns
//   valid data only on the cycle a fixed-latency RAM would.
module tb_phaethon_mem_arbiter;

  localparam int unsigned NumCh = 4;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned RdLat = 3;

  typedef struct {
    int          ch;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] arbDebug;

  exp_t        sb_q[$];
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  int          keep    [NumCh];
  int          rd_age;
  int          n_checks;
  int          n_fails;

  phaethon_mem_arbiter_if #(.NUM_CH(NumCh), .ADDR_W(AddrW), .DATA_W(DataW)) bus ();

  phaethon_mem_arbiter #(
    .NUM_CH    (NumCh),
    .ADDR_W    (AddrW),
    .DATA_W    (DataW),
    .RD_LATENCY(RdLat)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .arbDebug(arbDebug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since the read strobe rose; data is only valid in the last one.
  always @(posedge clk or posedge reset) begin
    if (reset) rd_age <= 0;
    else       rd_age <= bus.phReadReq ? rd_age + 1 : 0;
  end

  assign bus.phRamRead = (bus.phReadReq && rd_age == int'(RdLat) - 1) ?
                         mem[bus.phRamAddress[7:0]] : {8'hEE, rd_age[23:0]};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input int ch, input bit rd, input bit wr,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.chReadReq[ch]                = rd;
    bus.chWriteReq[ch]               = wr;
    bus.chAddress[ch*AddrW +: AddrW] = addr;
    bus.chWrite[ch*DataW +: DataW]   = wdata;
  endtask

  task automatic expect_txn(input int ch, input bit rd, input logic [31:0] addr,
                            input logic [31:0] wdata);
    exp_t e;
    e.ch   = ch;
    e.rd   = rd;
    e.addr = addr;
    if (rd) begin
      e.data = ref_mem[addr[7:0]];
    end else begin
      e.data = wdata;
      ref_mem[addr[7:0]] = wdata;
    end
    sb_q.push_back(e);
  endtask

  // Runs the requesters and RAM until every queued completion is seen and the
  // arbiter is idle again, or the cycle budget runs out.
  task automatic service(input int budget);
    exp_t e;
    int   cyc;
    int   t0;
    int   strobes;
    bit   active;
    bit   done;
    cyc     = 0;
    t0      = 0;
    strobes = 0;
    active  = 1'b0;
    done    = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      cyc++;
      if ((bus.phReadReq || bus.phWriteReq) && !active) begin
        active  = 1'b1;
        t0      = cyc;
        strobes = 0;
        if (sb_q.size() == 0) begin
          check_val("spurious_grant", 1, 0);
        end else begin
          e = sb_q[0];
          check_val($sformatf("grant_ch%0d", e.ch), arbDebug[4:1], 64'(e.ch));
          check_val($sformatf("addr_ch%0d", e.ch), bus.phRamAddress, e.addr);
          check_val($sformatf("wstrobe_ch%0d", e.ch), bus.phWriteReq, !e.rd);
          if (!e.rd) check_val($sformatf("wdata_ch%0d", e.ch), bus.phRamWrite, e.data);
        end
      end
      if (bus.phReadReq || bus.phWriteReq) strobes++;
      if (bus.phWriteReq) mem[bus.phRamAddress[7:0]] = bus.phRamWrite;
      if (|bus.chRamReady) begin
        if (sb_q.size() == 0) begin
          check_val("spurious_ready", bus.chRamReady, 0);
        end else begin
          e = sb_q.pop_front();
          check_val($sformatf("ready_ch%0d", e.ch), bus.chRamReady, 64'(1) << e.ch);
          if (e.rd) check_val($sformatf("rdata_ch%0d", e.ch), bus.chRamRead, e.data);
          check_val($sformatf("latency_ch%0d", e.ch), cyc - t0, e.rd ? RdLat : 1);
          check_val($sformatf("strobe_len_ch%0d", e.ch), strobes, e.rd ? RdLat : 1);
        end
        active = 1'b0;
        for (int c = 0; c < int'(NumCh); c++) begin
          if (bus.chRamReady[c]) begin
            if (keep[c] > 0) begin
              keep[c]--;
            end else begin
              bus.chReadReq[c]  = 1'b0;
              bus.chWriteReq[c] = 1'b0;
            end
          end
        end
      end
      if (sb_q.size() == 0 && !arbDebug[0]) done = 1'b1;
    end
    check_val("drain", sb_q.size(), 0);
    check_val("idle_after_drain", arbDebug[0], 0);
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    bit saw;
    n_checks       = 0;
    n_fails        = 0;
    reset          = 1'b1;
    bus.chReadReq  = '0;
    bus.chWriteReq = '0;
    bus.chAddress  = '0;
    bus.chWrite    = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h1000_0000 + 32'(i);
      ref_mem[i] = 32'h1000_0000 + 32'(i);
    end
    mem[8'h10]     = 32'hDEAD_BEEF;
    ref_mem[8'h10] = 32'hDEAD_BEEF;
    for (int c = 0; c < int'(NumCh); c++) keep[c] = 0;

    repeat (2) @(negedge clk);
    check_val("rst_ready", bus.chRamReady, 0);
    check_val("rst_rdata", bus.chRamRead, 0);
    check_val("rst_addr", bus.phRamAddress, 0);
    check_val("rst_wdata", bus.phRamWrite, 0);
    check_val("rst_rdreq", bus.phReadReq, 0);
    check_val("rst_wrreq", bus.phWriteReq, 0);
    check_val("rst_debug", arbDebug, 0);
    reset = 1'b0;

    // All four read at once; ch0 keeps its request for one extra access.
    for (int c = 0; c < int'(NumCh); c++) drive_req(c, 1'b1, 1'b0, 32'h40 + 32'(4 * c), 32'h0);
    keep[0] = 1;
`ifdef MEMARB_FIXED_PRIO_EN
    expect_txn(0, 1'b1, 32'h40, 32'h0);
    expect_txn(0, 1'b1, 32'h40, 32'h0);
    expect_txn(1, 1'b1, 32'h44, 32'h0);
    expect_txn(2, 1'b1, 32'h48, 32'h0);
    expect_txn(3, 1'b1, 32'h4C, 32'h0);
`else
    expect_txn(0, 1'b1, 32'h40, 32'h0);
    expect_txn(1, 1'b1, 32'h44, 32'h0);
    expect_txn(2, 1'b1, 32'h48, 32'h0);
    expect_txn(3, 1'b1, 32'h4C, 32'h0);
    expect_txn(0, 1'b1, 32'h40, 32'h0);
`endif
    service(200);

    drive_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    expect_txn(0, 1'b1, 32'h10, 32'h0);
    service(50);

    drive_req(1, 1'b0, 1'b1, 32'h20, 32'h1234_5678);
    expect_txn(1, 1'b0, 32'h20, 32'h1234_5678);
    service(50);

    drive_req(0, 1'b1, 1'b0, 32'h20, 32'h0);
    expect_txn(0, 1'b1, 32'h20, 32'h0);
    service(50);

    drive_req(2, 1'b1, 1'b0, 32'h30, 32'h0);
    expect_txn(2, 1'b1, 32'h30, 32'h0);
    service(50);
    check_val("err_clear", arbDebug[5], 0);

    // Read and write together on one channel: served as a write, flagged.
    drive_req(0, 1'b1, 1'b1, 32'h50, 32'hCAFE_F00D);
    expect_txn(0, 1'b0, 32'h50, 32'hCAFE_F00D);
    service(50);
    check_val("err_set", arbDebug[5], 1);

    drive_req(3, 1'b1, 1'b0, 32'h50, 32'h0);
    expect_txn(3, 1'b1, 32'h50, 32'h0);
    service(50);
    check_val("err_hold", arbDebug[5], 1);

    // Reset during the second cycle of a read abandons it.
    drive_req(2, 1'b1, 1'b0, 32'h30, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.phReadReq) found = 1'b1;
    end
    check_val("midrd_grant", found, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("midrd_rdreq", bus.phReadReq, 0);
    check_val("midrd_ready", bus.chRamReady, 0);
    check_val("midrd_addr", bus.phRamAddress, 0);
    check_val("midrd_rdata", bus.chRamRead, 0);
    check_val("midrd_debug", arbDebug, 0);
    drive_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (|bus.chRamReady || bus.phReadReq || bus.phWriteReq) saw = 1'b1;
    end
    check_val("midrd_no_ready", saw, 0);

    drive_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    expect_txn(0, 1'b1, 32'h10, 32'h0);
    service(50);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/phaethon_mem_arbiter.md
Name: phaethon_mem_arbiter

Overview:
- Parametrised successor to the single-requester CPU memory path.
- Lets NUM_CH requesters (ALU memory controller, DMA, UART buffer, and so on) share one physical RAM port. The RAM port uses the same ph* signalling as the CPU top.
- Arbitrates round-robin by default, drives fixed-latency RAM reads and writes, and returns data with a one-cycle ready pulse per channel.
- Sits between the per-requester memory controllers and the physical RAM pins of the CPU top.

Parameters:
- NUM_CH, 2, number of requester channels; legal range 1..8.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RD_LATENCY, 1, cycles from phReadReq assertion to valid phRamRead; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- chReadReq  in  NUM_CH  per-channel read request; level, held until that channel's chRamReady.
- chWriteReq  in  NUM_CH  per-channel write request; level, held until that channel's chRamReady.
- chAddress  in  NUM_CH*ADDR_W  packed per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- chWrite  in  NUM_CH*DATA_W  packed per-channel write data.
- chRamRead  out  DATA_W  read data; broadcast to all channels, valid while chRamReady is high.
- chRamReady  out  NUM_CH  one-hot, one-cycle completion pulse.
- phRamRead  in  DATA_W  physical RAM read data.
- phRamAddress  out  ADDR_W  physical RAM address.
- phRamWrite  out  DATA_W  physical RAM write data.
- phReadReq  out  1  physical read strobe.
- phWriteReq  out  1  physical write strobe.
- arbDebug  out  32  {24'b0, state[1:0], errSticky, grant[3:0], busy}.

Behaviour:
- All outputs are registered.
- Reset values:
  - state IDLE.
  - All outputs 0.
  - Round-robin pointer rrPtr = 0; errSticky = 0.
  - Latency counter = 0.
- Reset asserted mid-transaction: in-flight access is abandoned immediately (asynchronous). No chRamReady is issued for it, and ph strobes drop at once.
- FSM has states IDLE, READ, WRITE, DONE.
- IDLE:
  - A channel is pending if chReadReq[i] or chWriteReq[i] is high.
  - Winner is the first pending channel searching upward from rrPtr, wrapping modulo NUM_CH.
  - On grant at edge E:
    - grant <= winner.
    - phRamAddress <= chAddress[winner].
    - If chWriteReq[winner]: phRamWrite <= chWrite[winner], phWriteReq <= 1, go to WRITE.
    - Otherwise: phReadReq <= 1, cnt <= RD_LATENCY-1, go to READ.
  - No pending channel: outputs unchanged, strobes 0.
- Read and write both high on the same channel: treated as a write; errSticky <= 1 until reset.
- READ:
  - phReadReq and phRamAddress held.
  - When cnt == 0, at that edge (E+RD_LATENCY):
    - chRamRead <= phRamRead.
    - chRamReady[grant] <= 1.
    - phReadReq <= 0.
    - Go to DONE.
  - Otherwise cnt decrements.
- WRITE:
  - Lasts exactly one cycle. At edge E+1: phWriteReq <= 0, chRamReady[grant] <= 1, go to DONE.
- DONE:
  - chRamReady is high for this cycle only.
  - At the next edge: chRamReady <= 0, rrPtr <= (grant+1) mod NUM_CH, go to IDLE.
  - chRamRead holds its value until the next read completes.
- Requester rule: deassert req on the cycle after seeing chRamReady. Because IDLE samples one cycle after DONE, a req still high later than that starts a new transaction.
- Latency from grant edge E to ready:
  - Read: ready high from edge E+RD_LATENCY to edge E+RD_LATENCY+1.
  - Write: ready high from edge E+1 to edge E+2.
- Throughput: one read per RD_LATENCY+2 cycles; one write per 3 cycles.
- Requests arriving while busy wait; a req withdrawn before grant is simply not served.
- Address and data are sampled only at grant; later changes are ignored.
- NUM_CH == 1: rrPtr stays 0; the grant field of arbDebug reads 0.
- busy = (state != IDLE).

Optional Feature:
- Macro: MEMARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-numbered pending channel always wins. rrPtr is not implemented, and its bits read 0 in debug.
- Undefined: round-robin as described in Behaviour.
- Timing and handshake are identical in both builds.

Test Plan:
- RD_LATENCY=1, ch0 read addr 0x10, RAM returns 0xDEADBEEF:
  - phReadReq high for 1 cycle with phRamAddress=0x10.
  - chRamReady=2'b01 for 1 cycle, 1 cycle after grant, with chRamRead=0xDEADBEEF.
- ch1 write addr 0x20 data 0x12345678:
  - phWriteReq high 1 cycle with addr 0x20 and data 0x12345678.
  - chRamReady=2'b10 one cycle later.
  - Read-back via ch0 returns 0x12345678.
- NUM_CH=4, all channels request reads simultaneously and hold:
  - Grants in order 0,1,2,3.
  - Ch0 re-requests immediately; next grant after 3 is 0.
  - With MEMARB_FIXED_PRIO_EN, ch0 wins every time it re-requests.
- RD_LATENCY=3, ch2 read:
  - phReadReq high exactly 3 cycles.
  - Ready at grant+3; data equals phRamRead sampled at that edge.
- Reset pulsed during READ cycle 2 (RD_LATENCY=3):
  - All outputs 0 immediately; no ready pulse.
  - After release, a fresh ch0 read completes normally.
- ch0 with chReadReq and chWriteReq both high:
  - Write performed.
  - arbDebug[5] (errSticky) = 1 and stays 1 until reset.
